// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes RV immediates, adds them to the PC and
// presents the result through a registered output slot backed by one skid slot.
//
//   state | meaning
//   EMPTY | no entry held; out_valid=0
//   ONE   | output slot holds an entry
//   TWO   | output slot and skid slot both hold entries; in_ready=0
module imm_gen_pipe #(
  parameter int XLEN   = 64,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_target,
  output logic              out_err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} bufState_t;

  bufState_t state, nextState;

  logic [63:0]     imm64;
  logic [XLEN-1:0] newImm;
  logic [XLEN-1:0] newTarget;
  logic            newErr;
  logic [XLEN-1:0] skidImm;
  logic [XLEN-1:0] skidTarget;
  logic            skidErr;
  logic            accept;
  logic            drain;
  logic            loadOutIn;
  logic            loadOutSkid;
  logic            loadSkid;
  logic            unusedBits;

  // Opcode bits never contribute to an immediate.
  assign unusedBits = ^{in_instr[6:0], imm64};

  // Immediates are built at 64 bits and truncated, so XLEN=32 needs no special case
  // except SHAMT, whose field width depends on XLEN.
  always_comb begin
    imm64  = '0;
    newErr = 1'b0;
    case (in_mode)
      MODE_W'(1): imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
      MODE_W'(2): imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
      MODE_W'(3): imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      MODE_W'(4): imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
      MODE_W'(5): imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
      MODE_W'(6): imm64 = {59'b0, in_instr[19:15]};
      MODE_W'(7): imm64 = (XLEN == 64) ? {58'b0, in_instr[25:20]}
                                       : {59'b0, in_instr[24:20]};
      default:    newErr = 1'b1;
    endcase
    newImm    = imm64[XLEN-1:0];
    newTarget = in_pc + newImm;
  end

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    nextState   = state;
    loadOutIn   = 1'b0;
    loadOutSkid = 1'b0;
    loadSkid    = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          nextState = ONE;
          loadOutIn = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            loadOutIn = 1'b1;
          end else if (accept) begin
            nextState = TWO;
            loadSkid  = 1'b1;
          end else if (drain) begin
            nextState = EMPTY;
          end
        end
        TWO: if (drain) begin
          nextState   = ONE;
          loadOutSkid = 1'b1;
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_imm    <= '0;
      out_target <= '0;
      out_err    <= 1'b0;
      skidImm    <= '0;
      skidTarget <= '0;
      skidErr    <= 1'b0;
    end else begin
      state    <= nextState;
      in_ready <= (nextState != TWO);
      if (loadOutIn) begin
        out_imm    <= newImm;
        out_target <= newTarget;
        out_err    <= newErr;
      end else if (loadOutSkid) begin
        out_imm    <= skidImm;
        out_target <= skidTarget;
        out_err    <= skidErr;
      end
      if (loadSkid) begin
        skidImm    <= newImm;
        skidTarget <= newTarget;
        skidErr    <= newErr;
      end
    end
  end

endmodule
